cprv_dmem: RTL and testbench
============================

CPRV_DMEM -- requirements
Module: cprv_dmem

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, giving the number of DATA_WIDTH words stored.
REQ-003 The block SHALL have parameter LATENCY, default 1, giving the cycles from request accept to response valid; legal range 1..15.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic rises on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have the port valid_dmem_i, input, 1 bit: request valid from the mem stage.
REQ-007 The block SHALL have the port ready_dmem_o, output, 1 bit: request ready to the mem stage.
REQ-008 The block SHALL have the port addr_dmem_i, input, DATA_WIDTH bits: request byte address.
REQ-009 The block SHALL have the port wdata_dmem_i, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have the port w_en_dmem_i, input, 1 bit: 1 = write request, 0 = read request.
REQ-011 The block SHALL have the port valid_mem_dmem_o, output, 1 bit: response valid to the mem stage.
REQ-012 The block SHALL have the port ready_mem_dmem_i, input, 1 bit: response ready from the mem stage.
REQ-013 The block SHALL have the port rdata_dmem_o, output, DATA_WIDTH bits: response read data.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-015 ready_dmem_o SHALL be 1 only in IDLE while out of reset; no combinational path from any input.
REQ-016 A request SHALL be accepted on a rising edge with valid_dmem_i=1 and ready_dmem_o=1; nothing else is sampled.
REQ-017 The word index SHALL be addr_dmem_i[$clog2(DEPTH)+2:3] (DATA_WIDTH=64): low 3 bits ignored (no misalign fault); bits above the index ignored, so out-of-range addresses wrap.
REQ-018 An accepted write SHALL update the indexed word on the accept edge with the full wdata_dmem_i; there are no byte strobes.
REQ-019 An accepted read SHALL capture the indexed word on the accept edge; rdata_dmem_o SHALL hold that snapshot regardless of later writes.
REQ-020 An accepted write SHALL also produce a response, with rdata_dmem_o = 0.
REQ-021 On accept with LATENCY=1 the FSM SHALL go IDLE->RESP, so valid_mem_dmem_o=1 in the first cycle after accept.
REQ-022 On accept with LATENCY>1 the FSM SHALL go IDLE->BUSY, load a 4-bit counter with LATENCY-1, decrement it each cycle, and go BUSY->RESP when the counter reaches 1; valid_mem_dmem_o SHALL rise exactly LATENCY cycles after the accept edge.
REQ-023 In RESP, valid_mem_dmem_o and rdata_dmem_o SHALL be held stable until an edge with ready_mem_dmem_i=1, then the FSM SHALL go RESP->IDLE; back-pressure of any length SHALL be honoured.
REQ-024 valid_mem_dmem_o SHALL be 0 in IDLE and BUSY; ready_mem_dmem_i outside RESP SHALL be ignored.
REQ-025 At most one request SHALL be outstanding; best-case throughput is one request per LATENCY+1 cycles.
REQ-026 valid_dmem_i asserted in BUSY or RESP SHALL be ignored and left pending; it SHALL be accepted in the first IDLE cycle if still asserted.

Reset
REQ-027 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear, and ready_dmem_o=0, valid_mem_dmem_o=0, rdata_dmem_o=0.
REQ-028 ready_dmem_o SHALL become 1 in the first cycle after rst_n returns to 1.
REQ-029 A reset during BUSY or RESP SHALL discard the pending response; a write already accepted SHALL remain committed.
REQ-030 Memory contents SHALL NOT be cleared by reset; reads of never-written words are undefined (X allowed).

Verification
REQ-031 Write then read, LATENCY=1: write addr 0x10 data 0xDEADBEEF_CAFEF00D -> response 1 cycle later with rdata=0; read addr 0x10 -> 1 cycle later rdata=0xDEADBEEF_CAFEF00D.
REQ-032 Latency count, LATENCY=4: read accepted at cycle N -> valid_mem_dmem_o=0 for N+1..N+3, =1 at N+4; ready_dmem_o=0 from N+1 until the response handshake.
REQ-033 Back-pressure: hold ready_mem_dmem_i=0 for 5 cycles in RESP -> valid and rdata stable throughout; handshake on the 6th cycle -> IDLE, ready_dmem_o=1 the next cycle.
REQ-034 Alias and misalign, DEPTH=1024: write addr 0x2000 data 0x1 -> read addr 0x0 returns 0x1; read addr 0x7 returns 0x1.
REQ-035 Reset mid-op: write addr 0x8 data 0x55 accepted, rst_n=0 in RESP -> valid=0, ready=0, rdata=0; after reset, read addr 0x8 returns 0x55.
REQ-036 Snapshot: read addr 0x18 (holds 0xAA) with ready_mem_dmem_i=0, no new request can be accepted -> rdata stays 0xAA; after the handshake, write 0xBB to 0x18, then read 0x18 -> 0xBB.

Source files
------------

// File: rtl/cprv_dmem.sv
// cprv_dmem: single-port data memory for the mem stage.
// One request outstanding at a time; the response appears LATENCY cycles
// after the request is accepted and is held until the mem stage takes it.
// Reads return a snapshot of the word taken on the accept edge.
// Writes commit on the accept edge and answer with all-zero read data.
module cprv_dmem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_dmem_i,
    output logic                  ready_dmem_o,
    input  logic [DATA_WIDTH-1:0] addr_dmem_i,
    input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
    input  logic                  w_en_dmem_i,
    output logic                  valid_mem_dmem_o,
    input  logic                  ready_mem_dmem_i,
    output logic [DATA_WIDTH-1:0] rdata_dmem_o
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         OFF_W    = $clog2(DATA_WIDTH / 8);
    // BUSY is entered with LATENCY-1 and left when the count reaches 1,
    // which places the first RESP cycle exactly LATENCY edges after accept.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    // Low while reset is held and for no cycle afterwards; keeps ready at 0
    // during reset without a combinational path from rst_n.
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_valid;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_unused_addr;

    // Byte offset within the word is dropped (no misalign fault) and
    // address bits above the index are dropped, so addresses wrap.
    assign w_idx         = addr_dmem_i[IDX_W+OFF_W-1:OFF_W];
    assign w_unused_addr = ^{addr_dmem_i[DATA_WIDTH-1:IDX_W+OFF_W], addr_dmem_i[OFF_W-1:0]};

    assign w_accept = valid_dmem_i & w_ready;

    // State register, latency counter and out-of-reset flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state logic: IDLE -> (BUSY ->) RESP -> IDLE on response handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ready_mem_dmem_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from registered state.
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = r_live;
            ST_RESP: w_valid = 1'b1;
            default: ;
        endcase
    end

    // Word write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && w_en_dmem_i) begin
            r_mem[w_idx] <= wdata_dmem_i;
        end
    end

    // Response data: snapshot of the word for reads, zero for writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= w_en_dmem_i ? '0 : r_mem[w_idx];
        end
    end

    assign ready_dmem_o     = w_ready;
    assign valid_mem_dmem_o = w_valid;
    assign rdata_dmem_o     = r_rdata;

endmodule

// File: tb/tb_cprv_dmem.sv
// Testbench for cprv_dmem: two instances (LATENCY=1 and LATENCY=4) driven
// by directed and random requests; a scoreboard queue per instance holds
// expected responses from a word-array reference model, and a monitor
// compares every response cycle, latency and ready behaviour.
module tb_cprv_dmem;

    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int NDUT  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i   [NDUT];
    logic          ready_o   [NDUT];
    logic [DW-1:0] addr_i    [NDUT];
    logic [DW-1:0] wdata_i   [NDUT];
    logic          w_en_i    [NDUT];
    logic          valid_o   [NDUT];
    logic          ready_mem [NDUT];
    logic [DW-1:0] rdata_o   [NDUT];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            cprv_dmem #(
                .DATA_WIDTH(DW),
                .DEPTH     (DEPTH),
                .LATENCY   ((gi == 0) ? 1 : 4)
            ) u_dut (
                .clk             (clk),
                .rst_n           (rst_n),
                .valid_dmem_i    (valid_i[gi]),
                .ready_dmem_o    (ready_o[gi]),
                .addr_dmem_i     (addr_i[gi]),
                .wdata_dmem_i    (wdata_i[gi]),
                .w_en_dmem_i     (w_en_i[gi]),
                .valid_mem_dmem_o(valid_o[gi]),
                .ready_mem_dmem_i(ready_mem[gi]),
                .rdata_dmem_o    (rdata_o[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [DW-1:0] exp;
        bit            chk;
        int            acc;
    } resp_t;

    resp_t         sb       [NDUT][$];
    logic [DW-1:0] mdl      [NDUT][DEPTH];
    bit            written  [NDUT][DEPTH];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_err    = 0;
    bit            mon_en   = 1'b0;
    bit            hold     [NDUT];
    int            bp_force [NDUT];
    bit            seen     [NDUT];
    int            wait_cnt [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Present one request at a negedge and hold it until accepted; the
    // model is updated and the expected response queued on the accept edge.
    task automatic issue(input int k, input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] data);
        int    idx;
        resp_t r;
        bit    done;
        done       = 1'b0;
        valid_i[k] = 1'b1;
        w_en_i[k]  = we;
        addr_i[k]  = addr;
        wdata_i[k] = data;
        for (int t = 0; t < 300 && !done; t++) begin
            if (ready_o[k] === 1'b1) begin
                @(posedge clk);
                idx   = int'((addr >> 3) % DEPTH);
                r.acc = cyc;
                r.chk = 1'b1;
                if (we) begin
                    mdl[k][idx]     = data;
                    written[k][idx] = 1'b1;
                    r.exp           = '0;
                end else begin
                    r.exp = mdl[k][idx];
                    r.chk = written[k][idx];
                end
                sb[k].push_back(r);
                done = 1'b1;
            end
            @(negedge clk);
        end
        valid_i[k] = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: got no accept, expected one within 300 cycles", k);
        end
    endtask

    task automatic drain(input int k);
        for (int t = 0; t < 200 && sb[k].size() != 0; t++) @(negedge clk);
        check("drain_empty", k, 64'(sb[k].size()), 64'd0);
    endtask

    task automatic monitor_one(input int k);
        resp_t r;
        check("ready_dmem_o", k, 64'(ready_o[k]), 64'(sb[k].size() == 0));
        if (valid_o[k] === 1'b1) begin
            if (sb[k].size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp dut%0d: got valid_mem_dmem_o=1, expected 0 with nothing outstanding", k);
                ready_mem[k] = 1'b1;
            end else begin
                r = sb[k][0];
                if (!seen[k]) begin
                    seen[k] = 1'b1;
                    check("latency", k, 64'(cyc - r.acc), 64'(lat_of(k)));
                    wait_cnt[k] = (bp_force[k] >= 0) ? bp_force[k] : int'($urandom_range(0, 3));
                end
                if (r.chk) check("rdata", k, rdata_o[k], r.exp);
                if (hold[k]) begin
                    ready_mem[k] = 1'b0;
                end else if (wait_cnt[k] > 0) begin
                    wait_cnt[k]--;
                    ready_mem[k] = 1'b0;
                end else begin
                    ready_mem[k] = 1'b1;
                    void'(sb[k].pop_front());
                    seen[k] = 1'b0;
                    $display("dut%0d response rdata=%h accepted_at=%0d", k, rdata_o[k], r.acc);
                end
            end
        end else begin
            ready_mem[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < NDUT; k++) monitor_one(k);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            valid_i[k]   = 1'b0;
            ready_mem[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", k, 64'(ready_o[k]), 64'd0);
            check("rst_valid", k, 64'(valid_o[k]), 64'd0);
            check("rst_rdata", k, rdata_o[k], 64'd0);
            sb[k].delete();
            seen[k] = 1'b0;
            hold[k] = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check("ready_after_reset", k, 64'(ready_o[k]), 64'd1);
        mon_en = 1'b1;
    endtask

    task automatic run_seq(input int k);
        logic [DW-1:0] addr;
        bit            we;
        issue(k, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
        issue(k, 1'b0, 64'h10, 64'h0);
        issue(k, 1'b1, 64'h2000, 64'h1);
        issue(k, 1'b0, 64'h0, 64'h0);
        issue(k, 1'b0, 64'h7, 64'h0);
        issue(k, 1'b1, 64'h18, 64'hAA);
        bp_force[k] = 5;
        issue(k, 1'b0, 64'h18, 64'h0);
        issue(k, 1'b1, 64'h18, 64'hBB);
        bp_force[k] = -1;
        issue(k, 1'b0, 64'h18, 64'h0);
        for (int i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = (64'($urandom) << 32) | (64'($urandom_range(0, 7)) << 13)
                 | (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7));
            issue(k, we, addr, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain(k);
    endtask

    initial begin
        bit both;
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            valid_i[k]   = 1'b0;
            addr_i[k]    = '0;
            wdata_i[k]   = '0;
            w_en_i[k]    = 1'b0;
            ready_mem[k] = 1'b0;
            hold[k]      = 1'b0;
            bp_force[k]  = -1;
            seen[k]      = 1'b0;
            wait_cnt[k]  = 0;
        end
        do_reset();

        fork
            run_seq(0);
            run_seq(1);
        join

        // Reset while a write response is being held in RESP.
        for (int k = 0; k < NDUT; k++) hold[k] = 1'b1;
        fork
            issue(0, 1'b1, 64'h8, 64'h55);
            issue(1, 1'b1, 64'h8, 64'h55);
        join
        both = 1'b0;
        for (int t = 0; t < 50 && !both; t++) begin
            if (valid_o[0] === 1'b1 && valid_o[1] === 1'b1) both = 1'b1;
            else @(negedge clk);
        end
        check("held_resp_seen", 0, 64'(both), 64'd1);
        do_reset();
        fork
            issue(0, 1'b0, 64'h8, 64'h0);
            issue(1, 1'b0, 64'h8, 64'h0);
        join
        drain(0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
